// File: rtl/hdmi_rx_pkg.sv
// Shared definitions for the HDMI data-island receive path: guard-band symbol,
// BCH polynomial, TERC4 decode, ECC step and receiver state encoding.
package hdmi_rx_pkg;

    localparam logic [9:0] GUARD_BAND = 10'b0100110011;
    localparam logic [7:0] ECC_POLY   = 8'h83;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LGB,
        ST_DATA,
        ST_TGB
    } rx_state_e;

    // Returns {valid, nibble}; anything outside the 16 codes decodes as invalid.
    function automatic logic [4:0] terc4_decode(input logic [9:0] sym);
        case (sym)
            10'b1010011100: terc4_decode = {1'b1, 4'h0};
            10'b1001100011: terc4_decode = {1'b1, 4'h1};
            10'b1011100100: terc4_decode = {1'b1, 4'h2};
            10'b1011100010: terc4_decode = {1'b1, 4'h3};
            10'b0101110001: terc4_decode = {1'b1, 4'h4};
            10'b0100011110: terc4_decode = {1'b1, 4'h5};
            10'b0110001110: terc4_decode = {1'b1, 4'h6};
            10'b0100111100: terc4_decode = {1'b1, 4'h7};
            10'b1011001100: terc4_decode = {1'b1, 4'h8};
            10'b0100111001: terc4_decode = {1'b1, 4'h9};
            10'b0110011100: terc4_decode = {1'b1, 4'hA};
            10'b1011000110: terc4_decode = {1'b1, 4'hB};
            10'b1010001110: terc4_decode = {1'b1, 4'hC};
            10'b1001110001: terc4_decode = {1'b1, 4'hD};
            10'b0101100011: terc4_decode = {1'b1, 4'hE};
            10'b1011000011: terc4_decode = {1'b1, 4'hF};
            default:        terc4_decode = 5'b0_0000;
        endcase
    endfunction

    // One serial step of the LSB-first BCH(64,56)/(32,24) remainder register.
    function automatic logic [7:0] ecc_step(input logic [7:0] r, input logic b);
        logic f;
        f        = b ^ r[0];
        ecc_step = (r >> 1) ^ (f ? ECC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_ecc_serial.sv
// Serial BCH ECC accumulator; consumes BITS_PER_CYCLE bits per enabled cycle,
// data[0] first. Clear restarts the remainder from zero in the same cycle.
module bch_ecc_serial
    import hdmi_rx_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [BITS_PER_CYCLE-1:0] data,
    output logic [7:0]                ecc
);

    logic [7:0] ecc_q;
    logic [7:0] ecc_d;
    logic [7:0] acc;

    // Fold this cycle's bits into the remainder, starting from zero on clear.
    always_comb begin
        acc = clear ? 8'h00 : ecc_q;
        if (enable) begin
            for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                acc = ecc_step(acc, data[i]);
            end
        end
        ecc_d = (clear || enable) ? acc : ecc_q;
    end

    // Remainder register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ecc_q <= 8'h00;
        end else begin
            ecc_q <= ecc_d;
        end
    end

    assign ecc = ecc_q;

endmodule

// File: rtl/data_island_receiver.sv
// Data-island packet extractor: finds guard bands, TERC4-decodes island
// symbols, reassembles 32-cycle packets and checks header/subpacket BCH ECC.
module data_island_receiver
    import hdmi_rx_pkg::*;
#(
    parameter int MAX_PACKETS = 18
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic [9:0]  tmds0,
    input  logic [9:0]  tmds1,
    input  logic [9:0]  tmds2,
    output logic        packet_valid,
    output logic [23:0] header,
    output logic [55:0] sub0,
    output logic [55:0] sub1,
    output logic [55:0] sub2,
    output logic [55:0] sub3,
    output logic        header_ecc_ok,
    output logic [3:0]  sub_ecc_ok,
    output logic        packet_error,
    output logic        in_island
);

    localparam int PKT_W = $clog2(MAX_PACKETS + 1);

    logic [4:0]       dec0, dec1, dec2;
    logic             sym_valid, is_guard;
    logic             first_slot, marker_exp, island_end, take, abort;

    rx_state_e        state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [PKT_W-1:0] pkts_q, pkts_d;

    logic [30:0]      hdr_sr_q, hdr_sr_d;
    logic [61:0]      sub_sr_q [4];
    logic [61:0]      sub_sr_d [4];
    logic [31:0]      hdr_full;
    logic [63:0]      sub_full [4];

    logic             ecc_clear, hdr_ecc_en, sub_ecc_en;
    logic [7:0]       hdr_ecc;
    logic [7:0]       sub_ecc [4];

    logic             packet_valid_q, packet_valid_d;
    logic             packet_error_q, packet_error_d;
    logic [23:0]      header_q, header_d;
    logic [55:0]      sub_out_q [4];
    logic [55:0]      sub_out_d [4];
    logic             header_ecc_ok_q, header_ecc_ok_d;
    logic [3:0]       sub_ecc_ok_q, sub_ecc_ok_d;

    // Classify the incoming symbol set and decide whether the island accepts it.
    always_comb begin
        dec0       = terc4_decode(tmds0);
        dec1       = terc4_decode(tmds1);
        dec2       = terc4_decode(tmds2);
        sym_valid  = dec0[4] & dec1[4] & dec2[4];
        is_guard   = (tmds1 == GUARD_BAND) && (tmds2 == GUARD_BAND) &&
                     dec0[4] && (dec0[3:0] >= 4'hC);
        first_slot = (cnt_q == 5'd0) && (pkts_q != '0);
        marker_exp = !((cnt_q == 5'd0) && (pkts_q == '0));
        island_end = (state_q == ST_DATA) && first_slot && is_guard;
        take       = (state_q == ST_DATA) && !island_end && sym_valid &&
                     (dec0[3] == marker_exp) &&
                     !(first_slot && (pkts_q >= PKT_W'(MAX_PACKETS)));
        abort      = ((state_q == ST_DATA) && !island_end && !take) ||
                     ((state_q == ST_TGB) && !is_guard);
    end

    // Island sequencing: leading guard bands, packet slots, trailing guard band.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkts_d  = pkts_q;
        case (state_q)
            ST_IDLE: begin
                if (is_guard) state_d = ST_LGB;
            end
            ST_LGB: begin
                if (is_guard) begin
                    state_d = ST_DATA;
                    cnt_d   = 5'd0;
                    pkts_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (island_end) begin
                    state_d = ST_TGB;
                end else if (take) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) pkts_d = pkts_q + PKT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TGB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bit reassembly, ECC control and the registered packet outputs.
    always_comb begin
        hdr_full   = {dec0[2], hdr_sr_q};
        hdr_sr_d   = take ? hdr_full[31:1] : hdr_sr_q;
        ecc_clear  = take && (cnt_q == 5'd0);
        hdr_ecc_en = take && (cnt_q < 5'd24);
        sub_ecc_en = take && (cnt_q < 5'd28);

        packet_valid_d  = take && (cnt_q == 5'd31);
        packet_error_d  = abort;
        header_d        = header_q;
        header_ecc_ok_d = header_ecc_ok_q;
        sub_ecc_ok_d    = sub_ecc_ok_q;

        for (int k = 0; k < 4; k++) begin
            sub_full[k]  = {dec2[k], dec1[k], sub_sr_q[k]};
            sub_sr_d[k]  = take ? sub_full[k][63:2] : sub_sr_q[k];
            sub_out_d[k] = sub_out_q[k];
        end

        if (packet_valid_d) begin
            header_d        = hdr_full[23:0];
            header_ecc_ok_d = (hdr_ecc == hdr_full[31:24]);
            for (int k = 0; k < 4; k++) begin
                sub_out_d[k]    = sub_full[k][55:0];
                sub_ecc_ok_d[k] = (sub_ecc[k] == sub_full[k][63:56]);
            end
        end
    end

    bch_ecc_serial #(
        .BITS_PER_CYCLE(1)
    ) u_hdr_ecc (
        .clk     (clk_pixel),
        .reset_n (reset_n),
        .clear   (ecc_clear),
        .enable  (hdr_ecc_en),
        .data    (dec0[2]),
        .ecc     (hdr_ecc)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        bch_ecc_serial #(
            .BITS_PER_CYCLE(2)
        ) u_sub_ecc (
            .clk     (clk_pixel),
            .reset_n (reset_n),
            .clear   (ecc_clear),
            .enable  (sub_ecc_en),
            .data    ({dec2[k], dec1[k]}),
            .ecc     (sub_ecc[k])
        );
    end

    // State, counters, shift registers and output registers.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 5'd0;
            pkts_q          <= '0;
            hdr_sr_q        <= '0;
            packet_valid_q  <= 1'b0;
            packet_error_q  <= 1'b0;
            header_q        <= '0;
            header_ecc_ok_q <= 1'b0;
            sub_ecc_ok_q    <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                sub_sr_q[k]  <= '0;
                sub_out_q[k] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pkts_q          <= pkts_d;
            hdr_sr_q        <= hdr_sr_d;
            packet_valid_q  <= packet_valid_d;
            packet_error_q  <= packet_error_d;
            header_q        <= header_d;
            header_ecc_ok_q <= header_ecc_ok_d;
            sub_ecc_ok_q    <= sub_ecc_ok_d;
            for (int k = 0; k < 4; k++) begin
                sub_sr_q[k]  <= sub_sr_d[k];
                sub_out_q[k] <= sub_out_d[k];
            end
        end
    end

    assign packet_valid  = packet_valid_q;
    assign packet_error  = packet_error_q;
    assign header        = header_q;
    assign sub0          = sub_out_q[0];
    assign sub1          = sub_out_q[1];
    assign sub2          = sub_out_q[2];
    assign sub3          = sub_out_q[3];
    assign header_ecc_ok = header_ecc_ok_q;
    assign sub_ecc_ok    = sub_ecc_ok_q;
    assign in_island     = (state_q == ST_DATA) || (state_q == ST_TGB);

endmodule

// File: tb/tb_data_island_receiver.sv
// Directed bench for data_island_receiver: builds TERC4 islands from packet
// contents, drives them symbol by symbol and checks the decoded results.
module tb_data_island_receiver;

    localparam logic [9:0]  GB      = 10'b0100110011;
    localparam logic [9:0]  CTRL    = 10'b1101010100;
    localparam logic [55:0] ACR_SUB = 56'h00_18_00_0A_22_01_00;
    localparam logic [55:0] ALT_SUB = 56'h11_22_33_44_55_66_77;

    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic [9:0]  tmds0, tmds1, tmds2;
    logic        packet_valid;
    logic [23:0] header;
    logic [55:0] sub0, sub1, sub2, sub3;
    logic        header_ecc_ok;
    logic [3:0]  sub_ecc_ok;
    logic        packet_error;
    logic        in_island;

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int validCount   = 0;
    int errorCount   = 0;
    int islandCycles = 0;
    int validCyc[$];

    logic [9:0] sym0 [32];
    logic [9:0] sym1 [32];
    logic [9:0] sym2 [32];

    data_island_receiver #(
        .MAX_PACKETS(18)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset_n       (reset_n),
        .tmds0         (tmds0),
        .tmds1         (tmds1),
        .tmds2         (tmds2),
        .packet_valid  (packet_valid),
        .header        (header),
        .sub0          (sub0),
        .sub1          (sub1),
        .sub2          (sub2),
        .sub3          (sub3),
        .header_ecc_ok (header_ecc_ok),
        .sub_ecc_ok    (sub_ecc_ok),
        .packet_error  (packet_error),
        .in_island     (in_island)
    );

    // Free-running pixel clock.
    always #5 clk_pixel = ~clk_pixel;

    // Cycle index used to time-stamp output pulses.
    always @(posedge clk_pixel) cyc <= cyc + 1;

    // Pulse and island-occupancy tally, sampled mid-cycle.
    always @(negedge clk_pixel) begin
        if (packet_valid) begin
            validCount <= validCount + 1;
            validCyc.push_back(cyc);
        end
        if (packet_error) errorCount <= errorCount + 1;
        if (in_island) islandCycles <= islandCycles + 1;
    end

    function automatic logic [9:0] terc4Enc(input logic [3:0] nib);
        case (nib)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic logic [7:0] eccOf(input logic [63:0] bits, input int nbits);
        logic [7:0] r;
        logic       f;
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            f = bits[i] ^ r[0];
            r = (r >> 1) ^ (f ? 8'h83 : 8'h00);
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [9:0] t0, input logic [9:0] t1, input logic [9:0] t2);
        tmds0 = t0;
        tmds1 = t1;
        tmds2 = t2;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic sendGuard();
        applyStimulus(terc4Enc(4'hC), GB, GB);
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(CTRL, CTRL, CTRL);
    endtask

    task automatic buildPacket(input logic [23:0] hb, input logic [55:0] s0, input logic [55:0] s1,
                               input logic [55:0] s2, input logic [55:0] s3, input bit first,
                               input int flipBit);
        logic [31:0] h;
        logic [55:0] s [4];
        logic [63:0] sp [4];
        logic [3:0]  n0, n1, n2;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        h = {eccOf({40'h0, hb}, 24), hb};
        if (flipBit >= 0) h[flipBit] = ~h[flipBit];
        for (int k = 0; k < 4; k++) sp[k] = {eccOf({8'h00, s[k]}, 56), s[k]};
        for (int n = 0; n < 32; n++) begin
            n0 = {(first && n == 0) ? 1'b0 : 1'b1, h[n], 2'(n)};
            for (int k = 0; k < 4; k++) begin
                n1[k] = sp[k][2*n];
                n2[k] = sp[k][2*n+1];
            end
            sym0[n] = terc4Enc(n0);
            sym1[n] = terc4Enc(n1);
            sym2[n] = terc4Enc(n2);
        end
    endtask

    task automatic sendRange(input int lo, input int hi);
        for (int n = lo; n <= hi; n++) applyStimulus(sym0[n], sym1[n], sym2[n]);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int vBase, eBase, iBase, qBase;
        reset_n = 1'b0;
        tmds0 = CTRL; tmds1 = CTRL; tmds2 = CTRL;
        @(posedge clk_pixel);
        #1;
        sendIdle(2);
        checkOutput("reset_valid", packet_valid, 0);
        checkOutput("reset_error", packet_error, 0);
        checkOutput("reset_island", in_island, 0);
        checkOutput("reset_header", header, 0);
        checkOutput("reset_sub0", sub0, 0);
        checkOutput("reset_hdr_ok", header_ecc_ok, 0);
        checkOutput("reset_sub_ok", sub_ecc_ok, 0);
        reset_n = 1'b1;
        sendIdle(2);

        $display("[TB] null packet");
        vBase = validCount; eBase = errorCount;
        sendGuard();
        checkOutput("lgb_no_island", in_island, 0);
        sendGuard();
        checkOutput("island_rise", in_island, 1);
        buildPacket(24'h0, 56'h0, 56'h0, 56'h0, 56'h0, 1'b1, -1);
        sendRange(0, 31);
        checkOutput("null_valid", packet_valid, 1);
        checkOutput("null_header", header, 0);
        checkOutput("null_sub0", sub0, 0);
        checkOutput("null_sub1", sub1, 0);
        checkOutput("null_sub2", sub2, 0);
        checkOutput("null_sub3", sub3, 0);
        checkOutput("null_hdr_ok", header_ecc_ok, 1);
        checkOutput("null_sub_ok", sub_ecc_ok, 4'hF);
        sendGuard();
        sendGuard();
        checkOutput("null_island_fall", in_island, 0);
        sendIdle(2);
        checkOutput("null_valid_low", packet_valid, 0);
        checkOutput("null_count", validCount - vBase, 1);
        checkOutput("null_no_error", errorCount - eBase, 0);

        $display("[TB] three back-to-back packets");
        vBase = validCount; eBase = errorCount; qBase = validCyc.size();
        sendGuard();
        sendGuard();
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b1, -1);
        sendRange(0, 31);
        checkOutput("acr_valid", packet_valid, 1);
        checkOutput("acr_header", header, 24'h000001);
        checkOutput("acr_sub0", sub0, ACR_SUB);
        checkOutput("acr_sub3", sub3, ACR_SUB);
        checkOutput("acr_hdr_ok", header_ecc_ok, 1);
        checkOutput("acr_sub_ok", sub_ecc_ok, 4'hF);
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b0, 5);
        sendRange(0, 31);
        checkOutput("flip_valid", packet_valid, 1);
        checkOutput("flip_header", header, 24'h000021);
        checkOutput("flip_hdr_ok", header_ecc_ok, 0);
        checkOutput("flip_sub_ok", sub_ecc_ok, 4'hF);
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b0, -1);
        sendRange(0, 31);
        checkOutput("third_valid", packet_valid, 1);
        checkOutput("third_hdr_ok", header_ecc_ok, 1);
        sendGuard();
        checkOutput("tgb_island", in_island, 1);
        checkOutput("tgb_valid_low", packet_valid, 0);
        checkOutput("hold_header", header, 24'h000001);
        sendGuard();
        checkOutput("tgb_island_fall", in_island, 0);
        sendIdle(2);
        checkOutput("b2b_count", validCount - vBase, 3);
        checkOutput("b2b_gap1", validCyc[qBase+1] - validCyc[qBase], 32);
        checkOutput("b2b_gap2", validCyc[qBase+2] - validCyc[qBase], 64);
        checkOutput("b2b_no_error", errorCount - eBase, 0);

        $display("[TB] invalid symbol abort");
        vBase = validCount; eBase = errorCount;
        sendGuard();
        sendGuard();
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b1, -1);
        sym1[5] = 10'h000;
        sendRange(0, 5);
        checkOutput("err_pulse", packet_error, 1);
        checkOutput("err_idle", in_island, 0);
        checkOutput("err_no_valid", packet_valid, 0);
        sendGuard();
        checkOutput("err_pulse_low", packet_error, 0);
        sendGuard();
        checkOutput("fresh_island", in_island, 1);
        buildPacket(24'h000002, ALT_SUB, ACR_SUB, ALT_SUB, ACR_SUB, 1'b1, -1);
        sendRange(0, 31);
        checkOutput("fresh_valid", packet_valid, 1);
        checkOutput("fresh_header", header, 24'h000002);
        checkOutput("fresh_sub0", sub0, ALT_SUB);
        checkOutput("fresh_sub1", sub1, ACR_SUB);
        checkOutput("fresh_ok", {header_ecc_ok, sub_ecc_ok}, 5'h1F);
        sendGuard();
        sendGuard();
        sendIdle(2);
        checkOutput("err_count", errorCount - eBase, 1);
        checkOutput("err_valid_count", validCount - vBase, 1);

        $display("[TB] lone guard band");
        vBase = validCount; eBase = errorCount; iBase = islandCycles;
        sendGuard();
        sendIdle(1);
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b1, -1);
        sendRange(0, 31);
        sendIdle(2);
        checkOutput("lone_no_island", islandCycles - iBase, 0);
        checkOutput("lone_no_valid", validCount - vBase, 0);
        checkOutput("lone_no_error", errorCount - eBase, 0);

        $display("[TB] reset mid-island");
        vBase = validCount; eBase = errorCount;
        sendGuard();
        sendGuard();
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b1, -1);
        sendRange(0, 20);
        reset_n = 1'b0;
        applyStimulus(sym0[21], sym1[21], sym2[21]);
        reset_n = 1'b1;
        checkOutput("rst_header", header, 0);
        checkOutput("rst_sub0", sub0, 0);
        checkOutput("rst_island", in_island, 0);
        checkOutput("rst_flags", {header_ecc_ok, sub_ecc_ok}, 0);
        sendIdle(1);
        sendGuard();
        sendGuard();
        sendRange(0, 31);
        checkOutput("post_rst_valid", packet_valid, 1);
        checkOutput("post_rst_header", header, 24'h000001);
        checkOutput("post_rst_sub2", sub2, ACR_SUB);
        checkOutput("post_rst_ok", {header_ecc_ok, sub_ecc_ok}, 5'h1F);
        sendGuard();
        sendGuard();
        sendIdle(2);
        checkOutput("rst_valid_count", validCount - vBase, 1);
        checkOutput("rst_error_count", errorCount - eBase, 0);

        $display("[TB] packet limit");
        vBase = validCount; eBase = errorCount;
        sendGuard();
        sendGuard();
        for (int p = 0; p < 18; p++) begin
            buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, p == 0, -1);
            sendRange(0, 31);
        end
        checkOutput("max_last_valid", packet_valid, 1);
        buildPacket(24'h000001, ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB, 1'b0, -1);
        applyStimulus(sym0[0], sym1[0], sym2[0]);
        checkOutput("max_overflow_error", packet_error, 1);
        checkOutput("max_idle", in_island, 0);
        sendIdle(2);
        checkOutput("max_count", validCount - vBase, 18);
        checkOutput("max_error_count", errorCount - eBase, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
